// File: rtl/square_tone_gen.sv
// Square-wave tone generator: plays one note command at a time, fetching the
// divider from the note-frequency table and toggling audio_out at the derived rate.
module square_tone_gen #(
    parameter int unsigned PRESCALE = 256,
    parameter int unsigned LEN_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note_addr,
    input  logic             note_high,
    input  logic [1:0]       note_octave,
    input  logic [LEN_W-1:0] note_len,
    input  logic             note_stop,
    input  logic             beat_tick,
    output logic [3:0]       db_addr,
    output logic             db_high,
    input  logic [7:0]       db_entry,
    output logic             audio_out,
    output logic             busy
);

    localparam int unsigned PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [1:0]       octave_q, octave_d;
    logic [LEN_W-1:0] len_q,    len_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [7:0]       limit_q,  limit_d;
    logic             rest_q,   rest_d;
    logic [PW-1:0]    presc_q,  presc_d;
    logic [7:0]       tone_q,   tone_d;
    logic             audio_q,  audio_d;
    logic [3:0]       addr_q,   addr_d;
    logic             high_q,   high_d;
    logic             busy_q,   busy_d;
    logic             ready_q,  ready_d;
    logic [7:0]       shifted;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        octave_d = octave_q;
        len_d    = len_q;
        remain_d = remain_q;
        limit_d  = limit_q;
        rest_d   = rest_q;
        presc_d  = presc_q;
        tone_d   = tone_q;
        audio_d  = audio_q;
        addr_d   = addr_q;
        high_d   = high_q;
        shifted  = db_entry >> octave_q;

        case (state_q)
            IDLE: begin
                if (note_valid) begin
                    state_d  = LOAD;
                    octave_d = note_octave;
                    len_d    = note_len;
                    addr_d   = note_addr;
                    high_d   = note_high;
                end
            end
            LOAD: begin
                rest_d   = (db_entry == 8'd0);
                limit_d  = (shifted == 8'd0) ? 8'd1 : shifted;
                presc_d  = '0;
                tone_d   = '0;
                audio_d  = 1'b0;
                remain_d = len_q;
                state_d  = (len_q == '0 || note_stop) ? IDLE : PLAY;
            end
            PLAY: begin
                // End of note wins over any toggle due on the same edge
                if (note_stop || (beat_tick && remain_q == LEN_W'(1))) begin
                    state_d  = IDLE;
                    audio_d  = 1'b0;
                    presc_d  = '0;
                    tone_d   = '0;
                    remain_d = '0;
                end else begin
                    if (beat_tick) begin
                        remain_d = remain_q - LEN_W'(1);
                    end
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        if (tone_q == limit_q - 8'd1) begin
                            tone_d = '0;
                            if (!rest_q) begin
                                audio_d = ~audio_q;
                            end
                        end else begin
                            tone_d = tone_q + 8'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            octave_q <= '0;
            len_q    <= '0;
            remain_q <= '0;
            limit_q  <= '0;
            rest_q   <= 1'b0;
            presc_q  <= '0;
            tone_q   <= '0;
            audio_q  <= 1'b0;
            addr_q   <= '0;
            high_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            octave_q <= octave_d;
            len_q    <= len_d;
            remain_q <= remain_d;
            limit_q  <= limit_d;
            rest_q   <= rest_d;
            presc_q  <= presc_d;
            tone_q   <= tone_d;
            audio_q  <= audio_d;
            addr_q   <= addr_d;
            high_q   <= high_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign note_ready = ready_q;
    assign busy       = busy_q;
    assign audio_out  = audio_q;
    assign db_addr    = addr_q;
    assign db_high    = high_q;

endmodule
